// File: rtl/img_hist_calc.sv
// Per-frame pixel histogram with ping-pong banks. The AXI4-Stream video passes through
// with zero latency, and the previous frame's bins can be read on a simple read port.
module img_hist_calc #(
  parameter int unsigned PX_WIDTH      = 10,
  parameter int unsigned TDATA_WIDTH   = 16,
  parameter int unsigned TDATA_WIDTH_B = 2,
  parameter int unsigned CNT_WIDTH     = 22
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [TDATA_WIDTH-1:0]   video_i_tdata,
  input  logic [TDATA_WIDTH_B-1:0] video_i_tstrb,
  input  logic [TDATA_WIDTH_B-1:0] video_i_tkeep,
  input  logic                     video_i_tvalid,
  input  logic                     video_i_tlast,
  input  logic                     video_i_tuser,
  input  logic                     video_i_tid,
  input  logic                     video_i_tdest,
  output logic                     video_i_tready,
  output logic [TDATA_WIDTH-1:0]   video_o_tdata,
  output logic [TDATA_WIDTH_B-1:0] video_o_tstrb,
  output logic [TDATA_WIDTH_B-1:0] video_o_tkeep,
  output logic                     video_o_tvalid,
  output logic                     video_o_tlast,
  output logic                     video_o_tuser,
  output logic                     video_o_tid,
  output logic                     video_o_tdest,
  input  logic                     video_o_tready,
  input  logic                     hist_rd_en_i,
  input  logic [PX_WIDTH-1:0]      hist_rd_addr_i,
  output logic [CNT_WIDTH-1:0]     hist_rd_data_o,
  output logic                     hist_rd_valid_o,
  output logic                     hist_frame_done_o,
  output logic                     hist_valid_o
);

  localparam int unsigned Bins = 2 ** PX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CntMax = '1;

  typedef enum logic [1:0] {StInit, StAccum, StClear} state_e;

  state_e state_q, state_d;
  logic [PX_WIDTH-1:0] clr_q, clr_d;
  logic wr_bank_q, wr_bank_d;
  logic started_q, started_d;
  logic done_arm_q, done_arm_d;
  logic sof_pass_q, sof_pass_d;
  logic hist_valid_d, frame_done_d;
  logic clr_en0, clr_en1;
  logic sof, hs;
  logic [PX_WIDTH-1:0] px;

  logic [CNT_WIDTH-1:0] bank0 [Bins];
  logic [CNT_WIDTH-1:0] bank1 [Bins];

  // Counting pipeline: s1 = read data back, s2 = write pending, s3 = written last cycle.
  logic                 s1_vld_q, s1_bank_q;
  logic [PX_WIDTH-1:0]  s1_addr_q;
  logic [CNT_WIDTH-1:0] rd_q;
  logic                 s2_vld_q, s2_bank_q;
  logic [PX_WIDTH-1:0]  s2_addr_q;
  logic [CNT_WIDTH-1:0] s2_cnt_q;
  logic                 s3_vld_q, s3_bank_q;
  logic [PX_WIDTH-1:0]  s3_addr_q;
  logic [CNT_WIDTH-1:0] s3_cnt_q;
  logic [CNT_WIDTH-1:0] base, inc;

  assign video_o_tdata = video_i_tdata;
  assign video_o_tstrb = video_i_tstrb;
  assign video_o_tkeep = video_i_tkeep;
  assign video_o_tlast = video_i_tlast;
  assign video_o_tuser = video_i_tuser;
  assign video_o_tid   = video_i_tid;
  assign video_o_tdest = video_i_tdest;

  assign px = video_i_tdata[PX_WIDTH-1:0];
  // After CLEAR the held SOF beat must pass once instead of triggering another swap.
  assign sof = video_i_tvalid & video_i_tuser & ~sof_pass_q;
  assign hs  = video_i_tvalid & video_i_tready;

  always_comb begin
    state_d        = state_q;
    clr_d          = clr_q;
    wr_bank_d      = wr_bank_q;
    started_d      = started_q;
    done_arm_d     = done_arm_q;
    sof_pass_d     = sof_pass_q;
    hist_valid_d   = hist_valid_o;
    frame_done_d   = 1'b0;
    video_i_tready = 1'b0;
    video_o_tvalid = 1'b0;
    clr_en0        = 1'b0;
    clr_en1        = 1'b0;
    unique case (state_q)
      StInit: begin
        clr_en0 = 1'b1;
        clr_en1 = 1'b1;
        clr_d   = clr_q + 1'b1;
        if (clr_q == '1) state_d = StAccum;
      end
      StAccum: begin
        if (sof) begin
          wr_bank_d  = ~wr_bank_q;
          started_d  = 1'b1;
          // Only a swap that closes a frame begun by an earlier SOF announces a histogram.
          done_arm_d = started_q;
          state_d    = StClear;
        end else begin
          video_i_tready = video_o_tready;
          video_o_tvalid = video_i_tvalid;
          if (video_i_tvalid && video_o_tready) sof_pass_d = 1'b0;
        end
      end
      StClear: begin
        clr_en0 = ~wr_bank_q;
        clr_en1 = wr_bank_q;
        clr_d   = clr_q + 1'b1;
        if (clr_q == '1) begin
          state_d    = StAccum;
          sof_pass_d = 1'b1;
          if (done_arm_q) begin
            frame_done_d = 1'b1;
            hist_valid_d = 1'b1;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    base = rd_q;
    if (s2_vld_q && s2_bank_q == s1_bank_q && s2_addr_q == s1_addr_q) begin
      base = s2_cnt_q;
    end else if (s3_vld_q && s3_bank_q == s1_bank_q && s3_addr_q == s1_addr_q) begin
      base = s3_cnt_q;
    end
    inc = (base == CntMax) ? base : base + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= StInit;
      clr_q             <= '0;
      wr_bank_q         <= 1'b0;
      started_q         <= 1'b0;
      done_arm_q        <= 1'b0;
      sof_pass_q        <= 1'b0;
      hist_valid_o      <= 1'b0;
      hist_frame_done_o <= 1'b0;
      hist_rd_valid_o   <= 1'b0;
      hist_rd_data_o    <= '0;
      s1_vld_q          <= 1'b0;
      s1_bank_q         <= 1'b0;
      s1_addr_q         <= '0;
      rd_q              <= '0;
      s2_vld_q          <= 1'b0;
      s2_bank_q         <= 1'b0;
      s2_addr_q         <= '0;
      s2_cnt_q          <= '0;
      s3_vld_q          <= 1'b0;
      s3_bank_q         <= 1'b0;
      s3_addr_q         <= '0;
      s3_cnt_q          <= '0;
    end else begin
      state_q           <= state_d;
      clr_q             <= clr_d;
      wr_bank_q         <= wr_bank_d;
      started_q         <= started_d;
      done_arm_q        <= done_arm_d;
      sof_pass_q        <= sof_pass_d;
      hist_valid_o      <= hist_valid_d;
      hist_frame_done_o <= frame_done_d;
      hist_rd_valid_o   <= hist_rd_en_i;
      if (hist_rd_en_i) begin
        hist_rd_data_o <= wr_bank_q ? bank0[hist_rd_addr_i] : bank1[hist_rd_addr_i];
      end
      s1_vld_q  <= hs;
      s1_bank_q <= wr_bank_q;
      s1_addr_q <= px;
      rd_q      <= wr_bank_q ? bank1[px] : bank0[px];
      s2_vld_q  <= s1_vld_q;
      s2_bank_q <= s1_bank_q;
      s2_addr_q <= s1_addr_q;
      s2_cnt_q  <= inc;
      s3_vld_q  <= s2_vld_q;
      s3_bank_q <= s2_bank_q;
      s3_addr_q <= s2_addr_q;
      s3_cnt_q  <= s2_cnt_q;
    end
  end

  // Clearing never targets the bank that in-flight writes are draining into.
  always_ff @(posedge clk_i) begin
    if (clr_en0) begin
      bank0[clr_q] <= '0;
    end else if (s2_vld_q && !s2_bank_q) begin
      bank0[s2_addr_q] <= s2_cnt_q;
    end
    if (clr_en1) begin
      bank1[clr_q] <= '0;
    end else if (s2_vld_q && s2_bank_q) begin
      bank1[s2_addr_q] <= s2_cnt_q;
    end
  end

endmodule
